// File: rtl/mem_port_arbiter.sv
// Data-memory port arbiter: speculative loads vs. retired stores, one outstanding
// fixed-latency load, mispredict kill, store aging. Optional perf counters: MEM_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int LOAD_LAT   = 1,
  parameter int STARVE_MAX = 4,
  parameter int ROB_SIZE   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_req_valid,
  output logic        ld_req_ready,
  input  logic [31:0] ld_req_addr,
  input  logic [2:0]  ld_req_func3,
  input  logic [6:0]  ld_req_pd,
  input  logic [4:0]  ld_req_rob,
  input  logic        st_req_valid,
  output logic        st_req_ready,
  input  logic [31:0] st_req_addr,
  input  logic [31:0] st_req_data,
  input  logic [2:0]  st_req_func3,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_func3,
  input  logic [31:0] mem_rdata,
  input  logic        mispredict,
  input  logic [4:0]  mispredict_tag,
  input  logic [4:0]  rob_head,
  output logic        ld_done,
  output logic [6:0]  ld_pd,
  output logic [4:0]  ld_rob,
  output logic [31:0] ld_data,
  output logic        busy,
  output logic [31:0] perf_ld_cnt,
  output logic [31:0] perf_st_cnt,
  output logic [31:0] perf_conf_cnt
);

  typedef enum logic {IDLE, LD_WAIT} state_e;

  state_e      state_q, state_d;
  logic [2:0]  lat_q, lat_d;
  logic [3:0]  starve_q, starve_d;
  logic [6:0]  pd_q, pd_d;
  logic [4:0]  rob_q, rob_d;

  logic ld_cand, st_gnt, ld_gnt, ld_younger, kill, done;

  // Adding a multiple of ROB_SIZE keeps the subtraction non-negative for any 5-bit tags.
  function automatic logic [4:0] age(input logic [4:0] t, input logic [4:0] h);
    return 5'((32'(t) + 32'(32 * ROB_SIZE) - 32'(h)) % 32'(ROB_SIZE));
  endfunction

  assign ld_younger = age(rob_q, rob_head) > age(mispredict_tag, rob_head);
  assign ld_cand    = (state_q == IDLE) && ld_req_valid && !mispredict;
  assign st_gnt     = st_req_valid && (!ld_cand || (starve_q == 4'(STARVE_MAX)));
  assign ld_gnt     = ld_cand && !st_gnt;
  assign kill       = (state_q == LD_WAIT) && mispredict && ld_younger;
  assign done       = (state_q == LD_WAIT) && (lat_q == 3'd0) && !kill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      lat_q    <= 3'd0;
      starve_q <= 4'd0;
      pd_q     <= 7'd0;
      rob_q    <= 5'd0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      pd_q     <= pd_d;
      rob_q    <= rob_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    pd_d    = pd_q;
    rob_d   = rob_q;
    case (state_q)
      IDLE: begin
        if (ld_gnt) begin
          state_d = LD_WAIT;
          lat_d   = 3'(LOAD_LAT - 1);
          pd_d    = ld_req_pd;
          rob_d   = ld_req_rob;
        end
      end
      LD_WAIT: begin
        if (kill || done) state_d = IDLE;
        else              lat_d   = lat_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (st_gnt)
      starve_d = 4'd0;
    else if (st_req_valid && (starve_q != 4'(STARVE_MAX)))
      starve_d = starve_q + 4'd1;
  end

  // All outputs are forced low while reset is held, independent of the inputs.
  always_comb begin
    ld_req_ready = 1'b0;
    st_req_ready = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    mem_func3    = 3'd0;
    ld_done      = 1'b0;
    ld_pd        = 7'd0;
    ld_rob       = 5'd0;
    ld_data      = 32'd0;
    busy         = 1'b0;
    if (!reset) begin
      ld_req_ready = ld_gnt;
      st_req_ready = st_gnt;
      busy         = (state_q == LD_WAIT);
      if (st_gnt) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = st_req_addr;
        mem_wdata = st_req_data;
        mem_func3 = st_req_func3;
      end else if (ld_gnt) begin
        mem_en    = 1'b1;
        mem_addr  = ld_req_addr;
        mem_func3 = ld_req_func3;
      end
      if (done) begin
        ld_done = 1'b1;
        ld_pd   = pd_q;
        ld_rob  = rob_q;
        ld_data = mem_rdata;
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_ld_q, perf_st_q, perf_conf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_ld_q   <= 32'd0;
      perf_st_q   <= 32'd0;
      perf_conf_q <= 32'd0;
    end else begin
      if (ld_gnt)                       perf_ld_q   <= perf_ld_q + 32'd1;
      if (st_gnt)                       perf_st_q   <= perf_st_q + 32'd1;
      if (ld_req_valid && st_req_valid) perf_conf_q <= perf_conf_q + 32'd1;
    end
  end

  assign perf_ld_cnt   = perf_ld_q;
  assign perf_st_cnt   = perf_st_q;
  assign perf_conf_cnt = perf_conf_q;
`else
  assign perf_ld_cnt   = 32'd0;
  assign perf_st_cnt   = 32'd0;
  assign perf_conf_cnt = 32'd0;
`endif

endmodule
